// File: rtl/interrupt_controller.sv
// interrupt_controller: bus-mapped interrupt controller; define INTC_ROUND_ROBIN_EN for rotating priority
module interrupt_controller #(
   parameter int unsigned NUM_SRC   = 4,
   parameter logic [7:0]  BASE_ADDR = 8'hE0
) (
   input  logic               i_clk,
   input  logic               i_reset,
   inout  wire  [7:0]         io_bus_data,
   input  logic [7:0]         i_bus_addr,
   input  logic               i_bus_we,
   input  logic [NUM_SRC-1:0] i_src_irq,
   output logic [NUM_SRC-1:0] o_src_ack,
   output logic               o_cpu_int_raise,
   input  logic               i_cpu_int_ack
);

   typedef enum logic [1:0] {ST_IDLE, ST_RAISE, ST_SERVICE} state_t;

   localparam logic [1:0] REG_PENDING = 2'd0;
   localparam logic [1:0] REG_MASK    = 2'd1;
   localparam logic [1:0] REG_VECTOR  = 2'd2;
   localparam logic [1:0] REG_CTRL    = 2'd3;

`ifdef INTC_ROUND_ROBIN_EN
   localparam logic RR_EN = 1'b1;
`else
   localparam logic RR_EN = 1'b0;
`endif

   state_t               r_state;
   state_t               w_state_nxt;
   logic [NUM_SRC-1:0]   r_pending;
   logic [NUM_SRC-1:0]   r_mask;
   logic [NUM_SRC-1:0]   r_src_ack;
   logic                 r_gie;
   logic                 r_valid;
   logic [2:0]           r_id;
   logic                 w_valid_nxt;
   logic [2:0]           w_id_nxt;
   logic [7:0]           r_rd_data;
   logic                 r_rd_en;

   logic                 w_in_range;
   logic [1:0]           w_reg;
   logic                 w_wr;
   logic                 w_rd;
   logic [7:0]           w_wdata;
   logic                 w_eoi;
   logic                 w_ack_taken;
   logic [NUM_SRC-1:0]   w_capture;
   logic [NUM_SRC-1:0]   w_w1c;
   logic [NUM_SRC-1:0]   w_svc_clr;
   logic [NUM_SRC-1:0]   w_req;
   logic                 w_req_any;
   logic [2:0]           w_start;
   logic [2*NUM_SRC-1:0] w_dbl;
   logic [NUM_SRC-1:0]   w_rot;
   logic [2:0]           w_rot_idx;
   logic [3:0]           w_sum;
   logic [2:0]           w_sel_id;
   logic [7:0]           w_rd_mux;
   logic                 w_unused;

   // Bus decode: the four registers occupy one 4-aligned window
   assign w_in_range  = (i_bus_addr[7:2] == BASE_ADDR[7:2]);
   assign w_reg       = i_bus_addr[1:0];
   assign w_wr        = w_in_range & i_bus_we;
   assign w_rd        = w_in_range & ~i_bus_we;
   assign w_wdata     = io_bus_data;
   assign w_eoi       = w_wr && (w_reg == REG_VECTOR);
   assign w_unused    = ^w_wdata;

   // A source in its ack cycle is blind, so a held level is captured only once
   assign w_capture   = i_src_irq & ~r_src_ack;
   assign w_w1c       = (w_wr && (w_reg == REG_PENDING)) ? w_wdata[NUM_SRC-1:0] : '0;
   assign w_ack_taken = (r_state == ST_RAISE) && i_cpu_int_ack;
   assign w_svc_clr   = w_ack_taken ? (NUM_SRC'(1) << r_id) : '0;
   assign w_req       = r_pending & r_mask;
   assign w_req_any   = |w_req;

`ifdef INTC_ROUND_ROBIN_EN
   logic [2:0] r_last;

   // Remember the last acknowledged source so the search rotates past it
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_last <= 3'(NUM_SRC - 1);
      else if (w_ack_taken) r_last <= r_id;
   end

   assign w_start = (r_last == 3'(NUM_SRC - 1)) ? 3'd0 : r_last + 3'd1;
`else
   assign w_start = 3'd0;
`endif

   // Rotate requests so the search origin sits at bit 0, then pick the lowest set bit
   always_comb begin
      w_dbl     = {w_req, w_req} >> w_start;
      w_rot     = w_dbl[NUM_SRC-1:0];
      w_rot_idx = 3'd0;
      for (int k = NUM_SRC - 1; k >= 0; k--)
         if (w_rot[k]) w_rot_idx = 3'(k);
      w_sum    = {1'b0, w_start} + {1'b0, w_rot_idx};
      w_sel_id = (w_sum >= 4'(NUM_SRC)) ? 3'(w_sum - 4'(NUM_SRC)) : w_sum[2:0];
   end

   // Next-state and vector logic of the request/service FSM
   always_comb begin
      w_state_nxt = r_state;
      w_id_nxt    = r_id;
      w_valid_nxt = r_valid;
      case (r_state)
         ST_IDLE: begin
            if (r_gie && w_req_any) begin
               w_state_nxt = ST_RAISE;
               w_id_nxt    = w_sel_id;
               w_valid_nxt = 1'b1;
            end
         end
         ST_RAISE: begin
            if (i_cpu_int_ack) begin
               w_state_nxt = ST_SERVICE;
            end else if (!r_gie) begin
               w_state_nxt = ST_IDLE;
               w_id_nxt    = 3'd0;
               w_valid_nxt = 1'b0;
            end
         end
         ST_SERVICE: begin
            if (w_eoi) begin
               w_state_nxt = ST_IDLE;
               w_id_nxt    = 3'd0;
               w_valid_nxt = 1'b0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_id_nxt    = 3'd0;
            w_valid_nxt = 1'b0;
         end
      endcase
   end

   // FSM state and latched vector
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_id    <= 3'd0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_id    <= w_id_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   // Capture raises into pending; a same-cycle capture overrides any clear
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_src_ack <= '0;
         r_pending <= '0;
      end else begin
         r_src_ack <= w_capture;
         r_pending <= (r_pending & ~(w_w1c | w_svc_clr)) | w_capture;
      end
   end

   // Software-writable mask and global enable
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_mask <= '0;
         r_gie  <= 1'b0;
      end else if (w_wr) begin
         if (w_reg == REG_MASK) r_mask <= w_wdata[NUM_SRC-1:0];
         if (w_reg == REG_CTRL) r_gie  <= w_wdata[0];
      end
   end

   // Read data selection for the addressed register
   always_comb begin
      w_rd_mux = (w_reg == REG_PENDING) ? 8'(r_pending) :
                 (w_reg == REG_MASK)    ? 8'(r_mask) :
                 (w_reg == REG_VECTOR)  ? {r_valid, 4'b0000, r_id} :
                                          {6'b000000, RR_EN, r_gie};
   end

   // Registered read port: data appears the cycle after the address
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_rd_en   <= 1'b0;
         r_rd_data <= 8'h00;
      end else begin
         r_rd_en <= w_rd;
         if (w_rd) r_rd_data <= w_rd_mux;
      end
   end

   assign io_bus_data     = r_rd_en ? r_rd_data : 8'bzzzz_zzzz;
   assign o_src_ack       = r_src_ack;
   assign o_cpu_int_raise = (r_state == ST_RAISE);

endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed bench for interrupt_controller
module tb_interrupt_controller;

   localparam logic [7:0] BASE = 8'hE0;
   localparam logic [7:0] A_PEND = BASE + 8'd0;
   localparam logic [7:0] A_MASK = BASE + 8'd1;
   localparam logic [7:0] A_VEC  = BASE + 8'd2;
   localparam logic [7:0] A_CTRL = BASE + 8'd3;
`ifdef INTC_ROUND_ROBIN_EN
   localparam logic RR = 1'b1;
`else
   localparam logic RR = 1'b0;
`endif
   localparam logic [7:0] CTRL_RST = RR ? 8'h02 : 8'h00;
   localparam logic [7:0] CTRL_ON  = RR ? 8'h03 : 8'h01;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   wire  [7:0] bus;
   logic [7:0] tb_dout = 8'h00;
   logic       tb_oe = 1'b0;
   logic [7:0] addr = 8'h00;
   logic       we = 1'b0;
   logic [3:0] irq = 4'h0;
   logic [3:0] src_ack;
   logic       raise;
   logic       cpu_ack = 1'b0;
   int         n_assert = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   assign bus = tb_oe ? tb_dout : 8'bzzzz_zzzz;
   for (genvar g = 0; g < 8; g++) begin : g_pu
      pullup (bus[g]);
   end

   interrupt_controller #(.NUM_SRC(4), .BASE_ADDR(BASE)) dut (
      .i_clk(clk),
      .i_reset(rst),
      .io_bus_data(bus),
      .i_bus_addr(addr),
      .i_bus_we(we),
      .i_src_irq(irq),
      .o_src_ack(src_ack),
      .o_cpu_int_raise(raise),
      .i_cpu_int_ack(cpu_ack)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      addr = a; we = 1'b1; tb_dout = d; tb_oe = 1'b1;
      @(negedge clk);
      addr = 8'h00; we = 1'b0; tb_oe = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
      @(negedge clk);
      addr = a; we = 1'b0;
      @(negedge clk);
      addr = 8'h00;
      check(tag, bus, exp);
   endtask

   task automatic pulse_irq(input logic [3:0] v);
      @(negedge clk);
      irq = v;
      @(negedge clk);
      irq = 4'h0;
   endtask

   task automatic pulse_cpu_ack();
      @(negedge clk);
      cpu_ack = 1'b1;
      @(negedge clk);
      cpu_ack = 1'b0;
   endtask

   task automatic serve(input string tag, input logic [7:0] exp_vec);
      rd_chk({tag, "_vec"}, A_VEC, exp_vec);
      check({tag, "_raise"}, {7'b0, raise}, 8'h01);
      pulse_cpu_ack();
      check({tag, "_drop"}, {7'b0, raise}, 8'h00);
      bus_wr(A_VEC, 8'h00);
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_raise", {7'b0, raise}, 8'h00);
      check("rst_ack", {4'b0, src_ack}, 8'h00);
      check("rst_bus_z", bus, 8'hFF);
      rd_chk("rst_pend", A_PEND, 8'h00);
      rd_chk("rst_mask", A_MASK, 8'h00);
      rd_chk("rst_vec", A_VEC, 8'h00);
      rd_chk("rst_ctrl", A_CTRL, CTRL_RST);

      // single source handshake and latency
      bus_wr(A_MASK, 8'h03);
      bus_wr(A_CTRL, 8'h01);
      rd_chk("ctrl_on", A_CTRL, CTRL_ON);
      @(negedge clk);
      irq = 4'b0010;
      @(negedge clk);
      check("s1_ack_n1", {4'b0, src_ack}, 8'h02);
      check("s1_raise_n1", {7'b0, raise}, 8'h00);
      irq = 4'h0;
      @(negedge clk);
      check("s1_ack_n2", {4'b0, src_ack}, 8'h00);
      check("s1_raise_n2", {7'b0, raise}, 8'h01);
      rd_chk("s1_vec", A_VEC, 8'h81);
      rd_chk("s1_pend", A_PEND, 8'h02);
      pulse_cpu_ack();
      check("s1_raise_ack", {7'b0, raise}, 8'h00);
      rd_chk("s1_pend_ack", A_PEND, 8'h00);
      rd_chk("s1_vec_svc", A_VEC, 8'h81);
      bus_wr(A_VEC, 8'h5A);
      rd_chk("s1_vec_eoi", A_VEC, 8'h00);
      check("s1_raise_eoi", {7'b0, raise}, 8'h00);

      // two sources at once: priority order
      bus_wr(A_MASK, 8'h07);
      @(negedge clk);
      irq = 4'b0101;
      @(negedge clk);
      check("s2_ack", {4'b0, src_ack}, 8'h05);
      irq = 4'h0;
      serve("s2_first", RR ? 8'h82 : 8'h80);
      serve("s2_second", RR ? 8'h80 : 8'h82);
      pulse_irq(4'b0101);
      serve("s2b_first", RR ? 8'h82 : 8'h80);
      serve("s2b_second", RR ? 8'h80 : 8'h82);
      rd_chk("s2_pend_done", A_PEND, 8'h00);

      // masked source, write-1-to-clear, unmask
      bus_wr(A_MASK, 8'h00);
      pulse_irq(4'b1000);
      @(negedge clk);
      check("s3_masked", {7'b0, raise}, 8'h00);
      rd_chk("s3_pend", A_PEND, 8'h08);
      bus_wr(A_PEND, 8'h08);
      rd_chk("s3_w1c", A_PEND, 8'h00);
      bus_wr(A_MASK, 8'h08);
      @(negedge clk);
      @(negedge clk);
      check("s3_no_int", {7'b0, raise}, 8'h00);
      pulse_irq(4'b1000);
      check("s3_raise_n1", {7'b0, raise}, 8'h00);
      @(negedge clk);
      check("s3_raise_n2", {7'b0, raise}, 8'h01);
      serve("s3", 8'h83);

      // GIE withdraw during RAISE, re-raise, mask does not withdraw
      pulse_irq(4'b1000);
      @(negedge clk);
      check("s4_raise", {7'b0, raise}, 8'h01);
      bus_wr(A_CTRL, 8'h00);
      check("s4_hold", {7'b0, raise}, 8'h01);
      @(negedge clk);
      check("s4_withdraw", {7'b0, raise}, 8'h00);
      rd_chk("s4_pend", A_PEND, 8'h08);
      rd_chk("s4_vec", A_VEC, 8'h00);
      bus_wr(A_CTRL, 8'h01);
      @(negedge clk);
      check("s4_reraise", {7'b0, raise}, 8'h01);
      bus_wr(A_MASK, 8'h00);
      @(negedge clk);
      check("s4_mask_keep", {7'b0, raise}, 8'h01);
      serve("s4", 8'h83);

      // reset while in SERVICE with pending sources and a live read
      bus_wr(A_MASK, 8'h05);
      pulse_irq(4'b0101);
      rd_chk("s5_vec", A_VEC, 8'h80);
      pulse_cpu_ack();
      pulse_irq(4'b0001);
      pulse_cpu_ack();
      check("s5_svc_ack_ign", {7'b0, raise}, 8'h00);
      rd_chk("s5_pend", A_PEND, 8'h05);
      @(negedge clk);
      addr = A_PEND; we = 1'b0; irq = 4'b0010;
      @(posedge clk);
      #2;
      rst = 1'b1; addr = 8'h00; irq = 4'h0;
      #1;
      check("s5_rst_bus", bus, 8'hFF);
      check("s5_rst_ack", {4'b0, src_ack}, 8'h00);
      check("s5_rst_raise", {7'b0, raise}, 8'h00);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      rd_chk("s5_pend_rst", A_PEND, 8'h00);
      rd_chk("s5_mask_rst", A_MASK, 8'h00);
      rd_chk("s5_vec_rst", A_VEC, 8'h00);
      rd_chk("s5_ctrl_rst", A_CTRL, CTRL_RST);
      bus_wr(A_MASK, 8'h01);
      bus_wr(A_CTRL, 8'h01);
      pulse_irq(4'b0001);
      serve("s5_idle", 8'h80);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Bus-mapped interrupt controller between the peripheral interrupt lines (timer, mouse and future sources) and one processor interrupt input.
- Captures per-source raise/ack handshakes into a pending register and applies a per-source mask and a global enable.
- Selects one source, raises the processor interrupt and exposes the selected source ID on the shared 8-bit data bus.
- Holds further interrupts off until software writes end-of-interrupt (EOI).

Parameters:
- NUM_SRC, 4, number of interrupt sources (1..8).
- BASE_ADDR, 8'hE0, first of four consecutive bus addresses. Must be 4-aligned.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- BUS_DATA  inout  8  shared data bus. Driven only during read cycles, else Z.
- BUS_ADDR  in  8  shared address bus.
- BUS_WE  in  1  bus write enable.
- SRC_IRQ  in  NUM_SRC  per-source interrupt raise. Level, held by the peripheral until acked.
- SRC_ACK  out  NUM_SRC  per-source acknowledge. 1-cycle pulse.
- CPU_INT_RAISE  out  1  interrupt request to the processor.
- CPU_INT_ACK  in  1  processor acknowledge. 1-cycle pulse.

Behaviour:
- Register map:
  - BASE+0 PENDING: read gives pending bits. Write-1-to-clear.
  - BASE+1 MASK: R/W, 1 = enabled.
  - BASE+2 VECTOR: read gives {valid, 4'b0, id[2:0]}. Any write is EOI.
  - BASE+3 CTRL: R/W. bit0 = GIE. Other bits read 0.
- Bits at index ≥ NUM_SRC read 0 and ignore writes.
- Reset values: PENDING=0, MASK=0, GIE=0, VECTOR=0, SRC_ACK=0, CPU_INT_RAISE=0, bus read driver off, FSM=IDLE.
- Source capture, each cycle for each i:
  - If SRC_IRQ[i]=1 and SRC_ACK[i]=0: set pending[i] and drive SRC_ACK[i]=1 next cycle.
  - During the ack cycle SRC_IRQ[i] is ignored, which prevents double capture.
  - A raise on an already-pending source is merged: acked, pending stays 1.
- Set vs clear in the same cycle (capture vs write-1-to-clear on pending[i]): set wins.
- Bus read:
  - Registered. Address valid with BUS_WE=0 at edge N gives data on BUS_DATA during cycle N+1.
  - Driver disabled in the cycle after a write or an out-of-range address.
- Bus write: takes effect at the clock edge where BUS_WE=1 and the address is in range.
- FSM states: IDLE, RAISE, SERVICE.
  - IDLE: if GIE=1 and (pending & mask) != 0, latch VECTOR.id = selected source, set valid=1, go RAISE. CPU_INT_RAISE=1 from the next cycle.
  - RAISE: CPU_INT_RAISE held at 1.
    - CPU_INT_ACK=1: clear pending[id], CPU_INT_RAISE=0, go SERVICE.
    - GIE written 0 before the ack: withdraw. CPU_INT_RAISE=0, valid=0, pending kept, go IDLE.
    - Masking the selected source during RAISE does not withdraw it.
  - SERVICE: wait for an EOI write, then valid=0 and go IDLE. New captures are pended only. Only an EOI write leaves SERVICE; GIE is ignored here.
- Default selection priority is fixed: lowest index wins.
- Latency: SRC_IRQ sampled high at edge N gives pending set at N, SRC_ACK high in cycle N+1, CPU_INT_RAISE high in cycle N+2 (GIE=1, mask set, FSM in IDLE).
- Simultaneous events:
  - CPU_INT_ACK together with a new capture of the same source: pending is cleared, then re-set (set wins). The source will be re-serviced.
  - EOI outside SERVICE: ignored.
- CPU_INT_ACK seen while in IDLE or SERVICE: ignored.
- RESET asserted mid-handshake: all state returns to reset values immediately. SRC_ACK pulses are cut short.

Optional Feature:
- Macro: INTC_ROUND_ROBIN_EN.
- Defined:
  - Rotating priority. The search starts at (last serviced id + 1) mod NUM_SRC.
  - The last-serviced pointer updates on CPU_INT_ACK and resets to NUM_SRC-1, so the first search starts at 0.
  - CTRL bit1 reads 1.
- Undefined: fixed lowest-index priority. CTRL bit1 reads 0.

Test Plan:
- Reset then read all four registers -> PENDING=00, MASK=00, VECTOR=00, CTRL=00 (CTRL=02 with INTC_ROUND_ROBIN_EN). CPU_INT_RAISE=0.
- MASK=0x03, CTRL=0x01, pulse SRC_IRQ[1] held until ack -> SRC_ACK[1] 1-cycle pulse in cycle N+1. CPU_INT_RAISE=1 at N+2. VECTOR reads 0x81. After CPU_INT_ACK, PENDING=00 and CPU_INT_RAISE=0. Write BASE+2 -> VECTOR=00.
- SRC_IRQ[0] and SRC_IRQ[2] raised together, MASK=0x07, GIE=1 -> id 0 serviced first. After ACK+EOI, id 2 raised.
  - With INTC_ROUND_ROBIN_EN, after servicing 2 then 0, a simultaneous 0 and 2 selects 2.
- MASK=0x00, raise source 3 -> PENDING=0x08, no CPU_INT_RAISE. Write MASK=0x08 -> CPU_INT_RAISE within 2 cycles. Write 0x08 to PENDING before setting the mask -> no interrupt.
- GIE cleared while in RAISE -> CPU_INT_RAISE drops next cycle, pending bit kept. Re-enable GIE -> interrupt re-raised.
- Assert RESET while in SERVICE with PENDING=0x05 -> all outputs 0, PENDING=00, BUS_DATA=Z, FSM returns to IDLE.
